countdown_timer: RTL and testbench



---
 rtl/countdown_timer_if.sv | 28 ++
 rtl/countdown_timer.sv | 113 +++++++++++
 tb/tb_countdown_timer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Request/status bundle between the seconds-pulse producer, the control logic and the
// countdown timer.
interface countdown_timer_if;
  logic       tick;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic       start;
  logic       pause;
  logic       clear;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [1:0] state;
  logic       running;
  logic       done;
  logic       expired;
  logic       load_err;

  modport master (
    output tick, load, load_min, load_sec, start, pause, clear,
    input  min_bcd, sec_bcd, state, running, done, expired, load_err
  );

  modport slave (
    input  tick, load, load_min, load_sec, start, pause, clear,
    output min_bcd, sec_bcd, state, running, done, expired, load_err
  );
endinterface

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer driven by one-second ticks; flags expiry with a done pulse
// and a held expired level.
module countdown_timer #(
  parameter bit         TICK_IS_LEVEL = 1'b0,
  parameter logic [7:0] MAX_MIN_BCD   = 8'h99
) (
  input logic              clk,
  input logic              reset,
  countdown_timer_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StPause   = 2'd2,
    StExpired = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] min_q, min_d, sec_q, sec_d;
  logic [7:0] min_dec, sec_dec;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       tick_q;
  logic       tick_evt, load_ok, count_zero;

  // In level mode only a rising edge counts, so a held-high tick decrements once.
  assign tick_evt   = TICK_IS_LEVEL ? (bus.tick & ~tick_q) : bus.tick;
  assign count_zero = (min_q == 8'h00) && (sec_q == 8'h00);

  assign load_ok = (bus.load_min[7:4] <= 4'd9) && (bus.load_min[3:0] <= 4'd9) &&
                   (bus.load_sec[7:4] <= 4'd5) && (bus.load_sec[3:0] <= 4'd9) &&
                   (bus.load_min <= MAX_MIN_BCD);

  always_comb begin
    sec_dec = sec_q;
    min_dec = min_q;
    if (sec_q[3:0] != 4'd0) begin
      sec_dec[3:0] = sec_q[3:0] - 4'd1;
    end else if (sec_q[7:4] != 4'd0) begin
      sec_dec = {sec_q[7:4] - 4'd1, 4'd9};
    end else begin
      // Minutes are never zero here: RUN is never entered or held at 00:00.
      sec_dec = 8'h59;
      if (min_q[3:0] != 4'd0) begin
        min_dec[3:0] = min_q[3:0] - 4'd1;
      end else begin
        min_dec = {min_q[7:4] - 4'd1, 4'd9};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.clear) begin
      state_d = StIdle;
      min_d   = 8'h00;
      sec_d   = 8'h00;
    end else if (bus.load) begin
      if (state_q != StRun) begin
        if (load_ok) begin
          state_d = StIdle;
          min_d   = bus.load_min;
          sec_d   = bus.load_sec;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (bus.pause) begin
      if (state_q == StRun) state_d = StPause;
    end else if (bus.start) begin
      if ((state_q == StIdle || state_q == StPause) && !count_zero) state_d = StRun;
    end else if (tick_evt && state_q == StRun) begin
      min_d = min_dec;
      sec_d = sec_dec;
      if (min_dec == 8'h00 && sec_dec == 8'h00) begin
        state_d = StExpired;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tick_q  <= bus.tick;
    end
  end

  assign bus.min_bcd  = min_q;
  assign bus.sec_bcd  = sec_q;
  assign bus.state    = state_q;
  assign bus.running  = (state_q == StRun);
  assign bus.expired  = (state_q == StExpired);
  assign bus.done     = done_q;
  assign bus.load_err = err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a pulse-mode instance checked through a scoreboard
// queue and a level-mode instance checked directly.
module tb_countdown_timer;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PAU  = 2'd2;
  localparam logic [1:0] S_EXP  = 2'd3;

  typedef struct {
    string      tag;
    logic [7:0] m;
    logic [7:0] s;
    logic [1:0] st;
    logic       dn;
    logic       er;
  } exp_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  exp_t sb[$];

  countdown_timer_if bus ();
  countdown_timer_if bus2 ();

  countdown_timer #(
    .TICK_IS_LEVEL(1'b0),
    .MAX_MIN_BCD  (8'h99)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  countdown_timer #(
    .TICK_IS_LEVEL(1'b1),
    .MAX_MIN_BCD  (8'h99)
  ) dut_lvl (
    .clk  (clk),
    .reset(reset),
    .bus  (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] want);
    tests++;
    assert (got === want)
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] m, input logic [7:0] s,
                      input logic [1:0] st, input logic dn, input logic er);
    exp_t e;
    e.tag = tag; e.m = m; e.s = s; e.st = st; e.dn = dn; e.er = er;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      cmp("scoreboard_empty", 8'd0, 8'd1);
      return;
    end
    e = sb.pop_front();
    cmp({e.tag, "_min"}, bus.min_bcd, e.m);
    cmp({e.tag, "_sec"}, bus.sec_bcd, e.s);
    cmp({e.tag, "_state"}, 8'(bus.state), 8'(e.st));
    cmp({e.tag, "_running"}, 8'(bus.running), 8'(e.st == S_RUN));
    cmp({e.tag, "_expired"}, 8'(bus.expired), 8'(e.st == S_EXP));
    cmp({e.tag, "_done"}, 8'(bus.done), 8'(e.dn));
    cmp({e.tag, "_load_err"}, 8'(bus.load_err), 8'(e.er));
  endtask

  // Advance one clock, sample 1 time unit after the edge, drop the one-cycle requests.
  task automatic step();
    @(posedge clk);
    #1;
    bus.tick = 1'b0;  bus.load = 1'b0;  bus.start = 1'b0;  bus.pause = 1'b0;
    bus.clear = 1'b0;
    bus2.tick = 1'b0; bus2.load = 1'b0; bus2.start = 1'b0; bus2.pause = 1'b0;
    bus2.clear = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    bus.load = 1'b1; bus.load_min = m; bus.load_sec = s;
  endtask

  initial begin
    int total;
    tests = 0;
    fails = 0;
    reset = 1'b0;
    bus.tick = 0;  bus.load = 0;  bus.start = 0;  bus.pause = 0;  bus.clear = 0;
    bus.load_min = 8'h00;  bus.load_sec = 8'h00;
    bus2.tick = 0; bus2.load = 0; bus2.start = 0; bus2.pause = 0; bus2.clear = 0;
    bus2.load_min = 8'h00; bus2.load_sec = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    push("reset", 8'h00, 8'h00, S_IDLE, 0, 0); check();
    reset = 1'b1;
    step();

    // 62-second countdown from 01:02
    do_load(8'h01, 8'h02); push("load_0102", 8'h01, 8'h02, S_IDLE, 0, 0); step(); check();
    bus.start = 1; push("start_0102", 8'h01, 8'h02, S_RUN, 0, 0); step(); check();
    for (int i = 1; i <= 62; i++) begin
      total = 62 - i;
      bus.tick = 1;
      push($sformatf("tick%0d", i), to_bcd(total / 60), to_bcd(total % 60),
           (total == 0) ? S_EXP : S_RUN, total == 0, 0);
      step(); check();
      if (i < 62) repeat (4) step();
    end
    push("done_fall", 8'h00, 8'h00, S_EXP, 0, 0); step(); check();

    // rejected loads and load during RUN
    do_load(8'h00, 8'h60); push("bad_sec", 8'h00, 8'h00, S_EXP, 0, 1); step(); check();
    do_load(8'h1A, 8'h00); push("bad_min", 8'h00, 8'h00, S_EXP, 0, 1); step(); check();
    push("err_fall", 8'h00, 8'h00, S_EXP, 0, 0); step(); check();
    do_load(8'h00, 8'h10); push("load_0010", 8'h00, 8'h10, S_IDLE, 0, 0); step(); check();
    bus.start = 1; push("start_0010", 8'h00, 8'h10, S_RUN, 0, 0); step(); check();
    do_load(8'h00, 8'h30); push("load_in_run", 8'h00, 8'h10, S_RUN, 0, 0); step(); check();

    // pause beats tick; ticks while paused are ignored
    bus.pause = 1; bus.tick = 1;
    push("pause_tick", 8'h00, 8'h10, S_PAU, 0, 0); step(); check();
    for (int i = 0; i < 3; i++) begin
      bus.tick = 1; push("paused_tick", 8'h00, 8'h10, S_PAU, 0, 0); step(); check();
    end
    bus.start = 1; push("resume", 8'h00, 8'h10, S_RUN, 0, 0); step(); check();
    bus.tick = 1; push("tick_0009", 8'h00, 8'h09, S_RUN, 0, 0); step(); check();

    // start and tick together: tick dropped
    bus.clear = 1; push("clear_run", 8'h00, 8'h00, S_IDLE, 0, 0); step(); check();
    do_load(8'h00, 8'h05); push("load_0005", 8'h00, 8'h05, S_IDLE, 0, 0); step(); check();
    bus.start = 1; bus.tick = 1;
    push("start_tick", 8'h00, 8'h05, S_RUN, 0, 0); step(); check();
    bus.tick = 1; push("tick_0004", 8'h00, 8'h04, S_RUN, 0, 0); step(); check();

    // start at 00:00 ignored; load beats start
    bus.clear = 1; push("clear2", 8'h00, 8'h00, S_IDLE, 0, 0); step(); check();
    bus.start = 1; push("start_zero", 8'h00, 8'h00, S_IDLE, 0, 0); step(); check();
    do_load(8'h00, 8'h01); bus.start = 1;
    push("load_over_start", 8'h00, 8'h01, S_IDLE, 0, 0); step(); check();

    // expire from 00:01, then clear
    bus.start = 1; push("start_0001", 8'h00, 8'h01, S_RUN, 0, 0); step(); check();
    bus.tick = 1; push("expire", 8'h00, 8'h00, S_EXP, 1, 0); step(); check();
    bus.clear = 1; push("clear_exp", 8'h00, 8'h00, S_IDLE, 0, 0); step(); check();

    // asynchronous reset mid-RUN at 01:23
    do_load(8'h01, 8'h23); push("load_0123", 8'h01, 8'h23, S_IDLE, 0, 0); step(); check();
    bus.start = 1; push("start_0123", 8'h01, 8'h23, S_RUN, 0, 0); step(); check();
    #3;
    reset = 1'b0;
    #1;
    push("async_reset", 8'h00, 8'h00, S_IDLE, 0, 0); check();
    #2;
    reset = 1'b1;
    bus.tick = 1; push("post_reset1", 8'h00, 8'h00, S_IDLE, 0, 0); step(); check();
    push("post_reset2", 8'h00, 8'h00, S_IDLE, 0, 0); step(); check();

    // level-mode instance: held tick counts once
    bus2.load = 1; bus2.load_min = 8'h00; bus2.load_sec = 8'h05;
    step();
    cmp("lvl_load_sec", bus2.sec_bcd, 8'h05);
    bus2.start = 1;
    step();
    cmp("lvl_start_state", 8'(bus2.state), 8'(S_RUN));
    for (int i = 0; i < 4; i++) begin
      bus2.tick = 1;
      step();
      cmp($sformatf("lvl_held%0d_sec", i), bus2.sec_bcd, 8'h04);
    end
    step();
    bus2.tick = 1;
    step();
    cmp("lvl_second_edge_sec", bus2.sec_bcd, 8'h03);
    cmp("lvl_state_run", 8'(bus2.running), 8'd1);

    if (sb.size() != 0) cmp("scoreboard_leftover", 8'(sb.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
